axis_packet_framer: RTL

- Upstream neighbour of the packet processing stage.
- Takes an unframed AXI-Stream byte source with optional source end-of-frame marks, buffers it in a small FIFO, and emits fixed-length packets of `len` beats with `m_last` on beat `len-1`.
- A source frame that ends early is zero-padded up to `len`.
- Its master port drives the processing stage's slave port (`s_data`/`s_valid`/`s_last`/`s_ready`).

---
 rtl/axis_packet_framer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axis_packet_framer.sv
// Packet framer: buffers an unframed AXI-Stream byte source in a small FIFO and
// emits fixed-length packets of `len` beats, zero-padding frames that end early.
module axis_packet_framer #(
  parameter int Data_width = 8,
  parameter int Depth      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_width-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [Data_width-1:0] len,
  output logic [Data_width-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  full,
  output logic                  empty,
  output logic [7:0]            pkt_count
);

  localparam int Ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int Cnt_w = $clog2(Depth + 1);

  typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

  state_t                state, state_n;
  logic [Data_width:0]   mem [Depth];
  logic [Ptr_w-1:0]      rd_ptr, wr_ptr;
  logic [Cnt_w-1:0]      count;
  logic [Data_width-1:0] bcnt, bcnt_n, len_q, len_q_n, last_idx;
  logic [Data_width-1:0] head_data, load_data;
  logic                  head_last, load, load_last, pop, push, load_en;

  assign full      = (count == Cnt_w'(Depth));
  assign empty     = (count == '0);
  assign s_ready   = !full && !rst;
  assign push      = s_valid && s_ready;
  assign load_en   = !m_valid || m_ready;
  assign {head_last, head_data} = mem[rd_ptr];
  assign last_idx  = len_q - Data_width'(1);

  always_comb begin
    state_n   = state;
    bcnt_n    = bcnt;
    len_q_n   = len_q;
    load      = 1'b0;
    load_data = '0;
    load_last = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && (len != '0) && load_en) begin
          load      = 1'b1;
          pop       = 1'b1;
          load_data = head_data;
          load_last = (len == Data_width'(1));
          len_q_n   = len;
          bcnt_n    = Data_width'(1);
          if (len == Data_width'(1)) state_n = IDLE;
          else if (head_last)        state_n = PAD;
          else                       state_n = SEND;
        end
      end
      SEND: begin
        if (load_en && !empty) begin
          load      = 1'b1;
          pop       = 1'b1;
          load_data = head_data;
          load_last = (bcnt == last_idx);
          bcnt_n    = bcnt + Data_width'(1);
          // Packet end wins over a coincident source-last: nothing left to pad.
          if (load_last)      state_n = IDLE;
          else if (head_last) state_n = PAD;
        end
      end
      PAD: begin
        if (load_en) begin
          load      = 1'b1;
          load_last = (bcnt == last_idx);
          bcnt_n    = bcnt + Data_width'(1);
          if (load_last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcnt      <= '0;
      len_q     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
      len_q <= len_q_n;
      // No beat at a load opportunity leaves a bubble; data/last keep their value.
      if (load_en) begin
        m_valid <= load;
        if (load) begin
          m_data <= load_data;
          m_last <= load_last;
        end
      end
      if (push) wr_ptr <= (wr_ptr == Ptr_w'(Depth - 1)) ? '0 : wr_ptr + Ptr_w'(1);
      if (pop)  rd_ptr <= (rd_ptr == Ptr_w'(Depth - 1)) ? '0 : rd_ptr + Ptr_w'(1);
      if (push && !pop)      count <= count + Cnt_w'(1);
      else if (pop && !push) count <= count - Cnt_w'(1);
      if (m_valid && m_ready && m_last) pkt_count <= pkt_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

endmodule
